// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame width and command codes used by the slave decoder.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  localparam int unsigned SPI_FRAME_W = 32;

  localparam logic [7:0] CMD_DRIVE_MOTOR = 8'h00;
  localparam logic [7:0] CMD_SEND_DATA   = 8'h01;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts clk_div cycles per half-period while enabled and flags the
// cycle on which SCLK should rise (low phase) or fall (high phase).
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned clk_div = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_high,
  output logic o_rise_en,
  output logic o_fall_en
);

  localparam int unsigned DivW = $clog2(clk_div + 1);

  logic [DivW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap    = (r_cnt == DivW'(clk_div - 1));
  assign o_rise_en = i_en & ~i_high & w_wrap;
  assign o_fall_en = i_en & i_high & w_wrap;

  // Half-period counter; held at zero outside LOW/HIGH so every phase starts fresh.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (!i_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DivW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI initiator with programmable CS setup/hold and SCLK divider.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned data_length = SPI_FRAME_W,
  parameter int unsigned clk_div     = 4,
  parameter int unsigned cs_setup    = 2,
  parameter int unsigned cs_hold     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [data_length-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic [data_length-1:0] rx_data,
  output logic                   SPI_CLK,
  output logic                   CS,
  output logic                   outgoing,
  input  logic                   incoming
);

  localparam int unsigned BitW    = $clog2(data_length + 1);
  localparam int unsigned WaitMax = (cs_setup > cs_hold) ? cs_setup : cs_hold;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  spi_state_t             r_state;
  logic [WaitW-1:0]       r_wait;
  logic [BitW-1:0]        r_bits;
  logic [data_length-1:0] r_tx;
  logic [data_length-1:0] r_rx;
  logic [data_length-1:0] r_rx_data;
  logic                   r_sclk;
  logic                   r_cs;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sclk_en;
  logic                   w_high;

  assign w_sclk_en = (r_state == LOW) || (r_state == HIGH);
  assign w_high    = (r_state == HIGH);

  spi_sclk_gen #(
    .clk_div (clk_div)
  ) u_sclk_gen (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (w_sclk_en),
    .i_high    (w_high),
    .o_rise_en (w_rise),
    .o_fall_en (w_fall)
  );

  // MOSI is the MSB of the transmit shifter, so it is a flop output with no extra register.
  assign outgoing = r_tx[data_length-1];
  assign SPI_CLK  = r_sclk;
  assign CS       = r_cs;
  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;

  // Frame sequencer plus transmit/receive shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_tx    <= tx_data;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_wait  <= '0;
            r_bits  <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_wait == WaitW'(cs_setup - 1)) begin
            r_wait  <= '0;
            r_state <= LOW;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        LOW: begin
          if (w_rise) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_sclk <= 1'b0;
            r_rx   <= {r_rx[data_length-2:0], incoming};
            r_bits <= r_bits + BitW'(1);
            if (r_bits == BitW'(data_length - 1)) begin
              // Last bit: leave MOSI on it until CS rises.
              r_state <= HOLD;
            end else begin
              r_tx    <= {r_tx[data_length-2:0], 1'b0};
              r_state <= LOW;
            end
          end
        end
        HOLD: begin
          if (r_wait == WaitW'(cs_hold - 1)) begin
            r_wait    <= '0;
            r_cs      <= 1'b1;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_tx      <= '0;
            r_state   <= GAP;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        GAP: begin
          if (r_wait == WaitW'(cs_hold - 1)) begin
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master: default-parameter instance with a loopback /
// slave model, and a minimal-parameter 8-bit instance for corner timing.
module tb_spi_master;
  import spi_pkg::*;

  localparam int N        = 32;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int EXP_LOW  = CS_SETUP + 2 * CLK_DIV * N + CS_HOLD;  // 260

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [N-1:0] tx_data;
  logic         busy, done, sclk, cs, mosi, miso;
  logic [N-1:0] rx_data;
  logic         loop_en = 1'b1;
  logic         miso_slave;

  logic         s_start;
  logic [7:0]   s_tx;
  logic         s_busy, s_done, s_sclk, s_cs, s_mosi;
  logic [7:0]   s_rx;

  int n_assert = 0;
  int n_fail   = 0;

  assign miso = loop_en ? mosi : miso_slave;

  spi_master u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .SPI_CLK  (sclk),
    .CS       (cs),
    .outgoing (mosi),
    .incoming (miso)
  );

  spi_master #(
    .data_length (8),
    .clk_div     (1),
    .cs_setup    (1),
    .cs_hold     (1)
  ) u_small (
    .clk      (clk),
    .reset    (reset),
    .start    (s_start),
    .tx_data  (s_tx),
    .busy     (s_busy),
    .done     (s_done),
    .rx_data  (s_rx),
    .SPI_CLK  (s_sclk),
    .CS       (s_cs),
    .outgoing (s_mosi),
    .incoming (s_mosi)
  );

  // Behavioural mode-0 slave: presents miso_word MSB first, updating after each SCLK fall,
  // and captures MOSI on each SCLK rise.
  logic [N-1:0] miso_word = '0;
  logic [N-1:0] slave_rx  = '0;
  int           fall_cnt  = 0;
  int           rises     = 0;
  int           done_cnt  = 0;
  logic [N-1:0] mw_shift;

  always @(negedge cs) fall_cnt = 0;
  always @(negedge sclk) fall_cnt = fall_cnt + 1;
  always @(posedge sclk) begin
    slave_rx = {slave_rx[N-2:0], mosi};
    rises    = rises + 1;
  end
  always @(posedge done) done_cnt = done_cnt + 1;

  always_comb begin
    mw_shift   = miso_word << fall_cnt;
    miso_slave = (fall_cnt < N) ? mw_shift[N-1] : 1'b0;
  end

  int  s_rises = 0;
  time s_first = 0;
  time s_last  = 0;
  always @(posedge s_sclk) begin
    if (s_rises == 0) s_first = $time;
    s_last  = $time;
    s_rises = s_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Continuous protocol rules on both instances.
  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ssclk = 1'b0, prev_smosi = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("cs_high_while_sclk", {30'd0, cs, sclk} == 2'b11, 1'b0);
      check("s_cs_high_while_sclk", {30'd0, s_cs, s_sclk} == 2'b11, 1'b0);
      if (prev_sclk && sclk) check("mosi_stable_high", mosi, prev_mosi);
      if (prev_ssclk && s_sclk) check("s_mosi_stable_high", s_mosi, prev_smosi);
    end
    prev_sclk  = sclk;
    prev_mosi  = mosi;
    prev_ssclk = s_sclk;
    prev_smosi = s_mosi;
  end

  // One frame on the default instance, checked against the protocol timing rules.
  task automatic run_frame(input logic [N-1:0] tx, input bit lb, input logic [N-1:0] sw,
                           input bit poke_mid, input bit poke_done);
    logic [N-1:0] exp_rx;
    int low;
    int dc0;
    exp_rx    = lb ? tx : sw;
    loop_en   = lb;
    miso_word = sw;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    tx_data = tx;
    start   = 1'b1;
    rises   = 0;
    dc0     = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check("accept_cs", cs, 1'b0);
    check("accept_busy", busy, 1'b1);
    tx_data = $urandom;
    low = 1;
    for (int k = 1; k < 1000 && cs === 1'b0; k++) begin
      start = poke_mid && (k == 5);
      @(negedge clk);
      if (cs === 1'b0) low++;
    end
    start = 1'b0;
    check("cs_low_cycles", low, EXP_LOW);
    check("done_at_cs_rise", done, 1'b1);
    check("rx_data", rx_data, exp_rx);
    check("sclk_rises", rises, N);
    if (!lb) check("slave_rx", slave_rx, tx);
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("gap_busy", busy, 1'b1);
    check("done_one_cycle", done, 1'b0);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("no_requeue_cs", cs, 1'b1);
    check("done_count", done_cnt - dc0, 1);
    check("rx_hold", rx_data, exp_rx);
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int k;
    k = 0;
    while (cs !== lvl && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) check(tag, cs, lvl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] addr0_val;
    logic [N-1:0] sw2;
    int gap;
    int dc0;
    int low;

    reset   = 1'b1;
    start   = 1'b0;
    tx_data = '0;
    s_start = 1'b0;
    s_tx    = '0;
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Loopback of the reference word, with ignored start pulses mid-frame and at done.
    run_frame(32'hA5C3_0F01, 1'b1, '0, 1'b1, 1'b1);

    // Slave-facing frames: drive-motor command, then a read request and its response.
    run_frame(32'h0000_1801, 1'b0, $urandom, 1'b0, 1'b0);
    addr0_val = $urandom | 32'h1;
    run_frame({CMD_SEND_DATA, 24'h0}, 1'b0, $urandom, 1'b0, 1'b0);
    sw2 = (slave_rx[31:24] == CMD_SEND_DATA) ? addr0_val : '0;
    run_frame(32'h0000_0000, 1'b0, sw2, 1'b0, 1'b0);
    check("readback", rx_data, addr0_val);

    // Randomized frames, alternating loopback and slave data.
    for (int i = 0; i < 6; i++) begin
      run_frame($urandom, i[0], $urandom, 1'b0, 1'b0);
    end

    // start held high: back-to-back frames with a cs_hold+1 CS-high gap.
    loop_en = 1'b1;
    @(negedge clk);
    tx_data = $urandom;
    start   = 1'b1;
    wait_cs(1'b0, "held_first_fall");
    wait_cs(1'b1, "held_first_rise");
    gap = 0;
    for (int k = 0; k < 100 && cs === 1'b1; k++) begin
      gap++;
      @(negedge clk);
    end
    check("held_gap", gap, CS_HOLD + 1);
    start = 1'b0;
    wait_cs(1'b1, "held_second_rise");
    repeat (4) @(negedge clk);
    check("held_idle", busy, 1'b0);

    // Asynchronous reset after bit 10 of a frame with a nonzero rx_data already held.
    check("pre_reset_rx_nonzero", rx_data != '0, 1'b1);
    loop_en   = 1'b0;
    miso_word = $urandom;
    tx_data   = $urandom;
    start     = 1'b1;
    rises     = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2000 && rises < 11; k++) @(negedge clk);
    check("reached_bit10", rises >= 11, 1'b1);
    dc0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_cs", cs, 1'b1);
    check("async_rst_sclk", sclk, 1'b0);
    check("async_rst_rx", rx_data, '0);
    check("async_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("no_done_after_reset", done_cnt - dc0, 0);
    check("idle_cs_after_reset", cs, 1'b1);
    run_frame($urandom, 1'b0, $urandom, 1'b0, 1'b0);

    // Minimal-parameter 8-bit instance in loopback.
    @(negedge clk);
    s_tx    = 8'h81;
    s_start = 1'b1;
    s_rises = 0;
    @(negedge clk);
    s_start = 1'b0;
    s_tx    = 8'h00;
    check("s_accept_cs", s_cs, 1'b0);
    low = 1;
    for (int k = 1; k < 200 && s_cs === 1'b0; k++) begin
      @(negedge clk);
      if (s_cs === 1'b0) low++;
    end
    check("s_cs_low_cycles", low, 18);
    check("s_done", s_done, 1'b1);
    check("s_rx", s_rx, 8'h81);
    check("s_rises", s_rises, 8);
    check("s_sclk_period", 32'(s_last - s_first), 32'(7 * 2 * 10));
    @(negedge clk);
    check("s_done_pulse", s_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
